// File: rtl/imm_ctrl.sv
// imm_ctrl: RV32I immediate capture into a 2-entry skid buffer; define IMM_CTRL_ILLEGAL_EN to flag unknown opcodes
module imm_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic [24:0] sext_din,
    output logic [2:0]  sext_op,
    input  logic [31:0] sext_ext,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_imm,
    output logic [31:0] out_pc,
    output logic [2:0]  out_fmt,
    output logic        out_illegal
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
`ifdef IMM_CTRL_ILLEGAL_EN
    typedef struct packed {
        logic [31:0] imm;
        logic [31:0] pc;
        logic [2:0]  fmt;
        logic        ill;
    } entry_t;
`else
    typedef struct packed {
        logic [31:0] imm;
        logic [31:0] pc;
        logic [2:0]  fmt;
    } entry_t;
`endif
    state_t state_q, state_d;
    entry_t main_q, main_d, skid_q, skid_d, new_e;
    logic [6:0] op;
    logic [2:0] fmt_raw;
    logic push, pop;
    assign op = in_inst[6:0];
    assign sext_din = in_inst[31:7];
    always_comb begin
        fmt_raw = (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73) ? 3'd0 :
                  (op == 7'h63) ? 3'd1 :
                  (op == 7'h6F) ? 3'd2 :
                  (op == 7'h23) ? 3'd3 :
                  (op == 7'h37 || op == 7'h17) ? 3'd4 :
                  (op == 7'h33) ? 3'd5 : 3'd7;
    end
`ifdef IMM_CTRL_ILLEGAL_EN
    assign sext_op = fmt_raw;
    assign out_illegal = main_q.ill;
`else
    assign sext_op = (fmt_raw == 3'd7) ? 3'd5 : fmt_raw;
    assign out_illegal = 1'b0;
`endif
    always_comb begin
        new_e.imm = (sext_op == 3'd5 || sext_op == 3'd7) ? 32'd0 : sext_ext;
        new_e.pc = in_pc;
        new_e.fmt = sext_op;
`ifdef IMM_CTRL_ILLEGAL_EN
        new_e.ill = (sext_op == 3'd7);
`endif
    end
    assign out_valid = (state_q != EMPTY);
    assign in_ready = (state_q != TWO);
    // a flushed cycle must not disturb the held entry data
    assign push = in_valid & in_ready & ~flush;
    assign pop = out_valid & out_ready;
    always_comb begin
        state_d = state_q;
        main_d = main_q;
        skid_d = skid_q;
        case (state_q)
            EMPTY: if (push) begin
                state_d = ONE;
                main_d = new_e;
            end
            ONE: if (push && pop) main_d = new_e;
                else if (push) begin
                    state_d = TWO;
                    skid_d = new_e;
                end else if (pop) state_d = EMPTY;
            TWO: if (pop) begin
                state_d = ONE;
                main_d = skid_q;
            end
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state_q <= state_d;
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end
    assign out_imm = main_q.imm;
    assign out_pc = main_q.pc;
    assign out_fmt = main_q.fmt;
endmodule

// File: tb/tb_imm_ctrl.sv
// tb_imm_ctrl: randomized + directed check of imm_ctrl against a queue-based reference model
module tb_imm_ctrl;
    logic        clk, rst, in_valid, flush, out_ready;
    logic [31:0] in_inst, in_pc, sext_ext, junk;
    logic        in_ready, out_valid, out_illegal;
    logic [24:0] sext_din;
    logic [2:0]  sext_op, out_fmt;
    logic [31:0] out_imm, out_pc;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] imm;
        logic [31:0] pc;
        logic [2:0]  fmt;
        logic        ill;
    } ent_t;
    ent_t q[$];
    bit live = 0;
    bit zero_out = 0;
    bit pu, po;

    imm_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .sext_din(sext_din), .sext_op(sext_op), .sext_ext(sext_ext),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_pc(out_pc), .out_fmt(out_fmt), .out_illegal(out_illegal)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [2:0] ref_fmt(input logic [6:0] op);
        case (op)
            7'h13, 7'h03, 7'h67, 7'h73: return 3'd0;
            7'h63: return 3'd1;
            7'h6F: return 3'd2;
            7'h23: return 3'd3;
            7'h37, 7'h17: return 3'd4;
            7'h33: return 3'd5;
`ifdef IMM_CTRL_ILLEGAL_EN
            default: return 3'd7;
`else
            default: return 3'd5;
`endif
        endcase
    endfunction

    function automatic logic [31:0] riscv_imm(input logic [31:0] i, input logic [2:0] f);
        case (f)
            3'd0: return {{20{i[31]}}, i[31:20]};
            3'd1: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd2: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd3: return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd4: return {i[31:12], 12'd0};
            default: return 32'd0;
        endcase
    endfunction

    // sign-extender stub; returns garbage for no-immediate formats so it must be ignored
    assign sext_ext = (sext_op == 3'd5 || sext_op == 3'd7) ? junk : riscv_imm({sext_din, 7'd0}, sext_op);

    function automatic ent_t make(input logic [31:0] inst, input logic [31:0] pc);
        ent_t e;
        e.fmt = ref_fmt(inst[6:0]);
        e.imm = riscv_imm(inst, e.fmt);
        e.pc = pc;
        e.ill = (e.fmt == 3'd7);
        return e;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            zero_out = 1;
        end else if (flush) q.delete();
        else begin
            pu = in_valid && q.size() < 2;
            po = q.size() > 0 && out_ready;
            if (po) void'(q.pop_front());
            if (pu) begin
                q.push_back(make(in_inst, in_pc));
                zero_out = 0;
            end
        end
        live = 1;
    end

    always @(negedge clk) if (live) begin
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("sext_din", 32'(sext_din), 32'(in_inst[31:7]));
        chk("sext_op", 32'(sext_op), 32'(ref_fmt(in_inst[6:0])));
        if (q.size() != 0) begin
            chk("out_imm", out_imm, q[0].imm);
            chk("out_pc", out_pc, q[0].pc);
            chk("out_fmt", 32'(out_fmt), 32'(q[0].fmt));
            chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
        end else if (zero_out) begin
            chk("rst_imm", out_imm, 32'd0);
            chk("rst_pc", out_pc, 32'd0);
            chk("rst_fmt", 32'(out_fmt), 32'd0);
            chk("rst_ill", 32'(out_illegal), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        junk = $urandom;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        in_valid = v;
        in_inst = inst;
        in_pc = pc;
    endtask

    task automatic chk_idle_zero(input string n);
        @(negedge clk);
        chk({n, "_valid"}, 32'(out_valid), 32'd0);
        chk({n, "_ready"}, 32'(in_ready), 32'd1);
        chk({n, "_imm"}, out_imm, 32'd0);
        chk({n, "_pc"}, out_pc, 32'd0);
        chk({n, "_fmt"}, 32'(out_fmt), 32'd0);
        chk({n, "_ill"}, 32'(out_illegal), 32'd0);
    endtask

    logic [6:0] ops [12];
    initial begin
        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h63, 7'h6F, 7'h23, 7'h37, 7'h17, 7'h33, 7'h00, 7'h7F};
        junk = 32'hDEADBEEF;
        rst = 1; flush = 0; out_ready = 1;
        drive(0, 32'h0, 32'h0);
        step(); step();
        rst = 0;
        chk_idle_zero("lit_reset");
        // addi x1,x0,-1
        step();
        drive(1, 32'hFFF00093, 32'h100);
        step();
        drive(0, 32'h0, 32'h0);
        @(negedge clk);
        chk("lit_i_valid", 32'(out_valid), 32'd1);
        chk("lit_i_imm", out_imm, 32'hFFFFFFFF);
        chk("lit_i_fmt", 32'(out_fmt), 32'd0);
        step();
        // beq x0,x0,-4 ; jal x0,0 ; lui x0,0x12345
        drive(1, 32'hFE000EE3, 32'h200); step(); @(negedge clk);
        chk("lit_b_imm", out_imm, 32'hFFFFFFFC);
        drive(1, 32'h0000006F, 32'h204); step(); @(negedge clk);
        chk("lit_j_imm", out_imm, 32'h00000000);
        drive(1, 32'h12345037, 32'h208); step(); @(negedge clk);
        chk("lit_u_imm", out_imm, 32'h12345000);
        drive(0, 32'h0, 32'h0); step();
        out_ready = 0;
        drive(1, 32'h00100093, 32'h300); step();
        drive(1, 32'h00200093, 32'h304); step();
        drive(1, 32'h00300093, 32'h308);
        @(negedge clk);
        chk("lit_bp_full", 32'(in_ready), 32'd0);
        step(); step(); @(negedge clk);
        chk("lit_bp_hold", out_pc, 32'h300);
        out_ready = 1;
        step(); @(negedge clk);
        chk("lit_bp_second", out_pc, 32'h304);
        step(); @(negedge clk);
        chk("lit_bp_third", out_pc, 32'h308);
        drive(0, 32'h0, 32'h0); step();
        out_ready = 0;
        drive(1, 32'h00500093, 32'h400); step();
        drive(1, 32'h00600093, 32'h404); step();
        flush = 1;
        drive(1, 32'h00700093, 32'h408); step();
        flush = 0;
        drive(0, 32'h0, 32'h0);
        @(negedge clk);
        chk("lit_fl_valid", 32'(out_valid), 32'd0);
        chk("lit_fl_ready", 32'(in_ready), 32'd1);
        out_ready = 1;
        step(); @(negedge clk);
        chk("lit_fl_empty", 32'(out_valid), 32'd0);
        drive(1, 32'h00000000, 32'h500); step();
        drive(0, 32'h0, 32'h0);
        @(negedge clk);
        chk("lit_ill_imm", out_imm, 32'd0);
`ifdef IMM_CTRL_ILLEGAL_EN
        chk("lit_ill_flag", 32'(out_illegal), 32'd1);
        chk("lit_ill_fmt", 32'(out_fmt), 32'd7);
`else
        chk("lit_ill_flag", 32'(out_illegal), 32'd0);
        chk("lit_ill_fmt", 32'(out_fmt), 32'd5);
`endif
        step();
        out_ready = 0;
        drive(1, 32'h00800093, 32'h600); step();
        drive(1, 32'h00900093, 32'h604); step();
        rst = 1; flush = 1;
        drive(1, 32'h00A00093, 32'h608); step();
        rst = 0; flush = 0;
        drive(0, 32'h0, 32'h0);
        chk_idle_zero("lit_rst_two");
        out_ready = 1;
        drive(1, 32'h00B00093, 32'h700); step();
        drive(0, 32'h0, 32'h0);
        @(negedge clk);
        chk("lit_post_rst_pc", out_pc, 32'h700);
        for (int i = 0; i < 3000; i++) begin
            step();
            rst = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 39) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_inst = {$urandom, ops[$urandom_range(0, 10)]} >> 7 << 7;
            in_inst[6:0] = ($urandom_range(0, 11) == 11) ? 7'($urandom) : ops[$urandom_range(0, 10)];
            in_pc = $urandom;
        end
        step();
        rst = 0; flush = 0; out_ready = 1;
        drive(0, 32'h0, 32'h0);
        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
